// File: rtl/accum_seq32.sv
// Purpose : registers the 32-bit signed running sum of a valid/ready packet and
//           a sticky signed-overflow flag, then presents sum/overflow/beat count.
// Latency : result valid the cycle after the last beat is accepted; min 2-cycle
//           packet spacing. Backpressure: in_ready drops while a result waits
//           for out_ready; the result is held stable until taken.
//
// Ports   : clk/rst_n            clock, asynchronous active-low reset
//           in_valid/in_ready    input beat handshake (in_data, in_last)
//           out_valid/out_ready  result handshake (out_sum, out_ov, out_count)
// Build   : define ACCUM_SAT_EN to clamp the accumulator on signed overflow
//           instead of wrapping.
module accum_seq32 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_ov,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [31:0]       acc;
    logic              ov_sticky;
    logic [CNT_W-1:0]  count;

    logic [31:0]       sum_dat;
    logic              add_ov;
    logic [31:0]       next_acc;
    logic              accept;

    // Carry-out of bit 31 is dropped; signed overflow is detected from signs.
    assign sum_dat = acc + in_data;
    assign add_ov  = (acc[31] == in_data[31]) && (sum_dat[31] != acc[31]);

`ifdef ACCUM_SAT_EN
    // On overflow both operands share a sign, so acc[31] picks the clamp rail.
    assign next_acc = add_ov ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_dat;
`else
    assign next_acc = sum_dat;
`endif

    // Gated by rst_n so no beat is advertised as acceptable during reset.
    assign in_ready = rst_n && (state != DONE);
    assign accept   = in_valid && in_ready;

    assign out_sum   = acc;
    assign out_ov    = ov_sticky;
    assign out_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 32'h0;
            ov_sticky <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Accumulator is zero here, so the first add cannot overflow.
                        acc       <= in_data;
                        count     <= CNT_ONE;
                        ov_sticky <= 1'b0;
                        state     <= in_last ? DONE : ACC;
                        out_valid <= in_last;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc       <= next_acc;
                        ov_sticky <= ov_sticky | add_ov;
                        if (count != CNT_MAX) begin
                            count <= count + CNT_ONE;
                        end
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= 32'h0;
                        ov_sticky <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_seq32.sv
// Purpose : directed and randomized packets against a sum/overflow/count model.
// Latency : checks result one cycle after the last accepted beat.
// Backpressure: holds out_ready low for random spans and checks the result holds.
module tb_accum_seq32;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'h0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_sum;
    logic             out_ov;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] beat_q[$];

    accum_seq32 #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ov    (out_ov),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, then wrap or clamp.
    task automatic model(output logic [31:0] s, output logic ov, output logic [CNT_W-1:0] c);
        longint a;
        longint t;
        longint max_pos;
        longint min_neg;
        logic [63:0] tv;
        max_pos = 64'sd2147483647;
        min_neg = -64'sd2147483648;
        a  = 0;
        ov = 1'b0;
        foreach (beat_q[i]) begin
            t = a + longint'(signed'(beat_q[i]));
            if (t > max_pos || t < min_neg) ov = 1'b1;
`ifdef ACCUM_SAT_EN
            if (t > max_pos)      a = max_pos;
            else if (t < min_neg) a = min_neg;
            else                  a = t;
`else
            tv = t;
            a  = longint'(signed'(tv[31:0]));
`endif
        end
        tv = a;
        s  = tv[31:0];
        c  = (beat_q.size() > 255) ? CNT_W'(255) : CNT_W'(beat_q.size());
    endtask

    // Sends beat_q with random gaps, checks the result and its hold, then takes it.
    task automatic run_packet(input string tag, input int gap_pct, input int hold,
                              input logic [31:0] es, input logic eo,
                              input logic [CNT_W-1:0] ec);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        while (idx < beat_q.size()) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(1));
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom_range(1));
            end else begin
                in_valid = 1'b1;
                in_data  = beat_q[idx];
                in_last  = (idx == beat_q.size() - 1);
            end
            if (in_valid && in_ready) idx++;
            budget++;
            if (budget > 5000) begin
                checks++;
                failures++;
                $error("FAIL %s_timeout observed=%0d expected=%0d beats", tag, idx, beat_q.size());
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   out_sum,        es);
        chk({tag, "_ov"},    32'(out_ov),    32'(eo));
        chk({tag, "_count"}, 32'(out_count), 32'(ec));
        chk({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(1));
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"},   out_sum,        es);
            chk({tag, "_hold_count"}, 32'(out_count), 32'(ec));
            chk({tag, "_hold_inrdy"}, 32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_taken_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_inrdy"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [31:0]      ms;
        logic             mo;
        logic [CNT_W-1:0] mc;
        int               len;

        // Reset state
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inrdy", 32'(in_ready),  32'd0);
        chk("rst_sum",   out_sum,        32'h0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ov",    32'(out_ov),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_inrdy", 32'(in_ready), 32'd1);

        // 1 + 2 + 3
        beat_q = '{32'd1, 32'd2, 32'd3};
        run_packet("p123", 0, 0, 32'd6, 1'b0, CNT_W'(3));

        // Positive overflow
        beat_q = '{32'h7FFF_FFFF, 32'h0000_0001};
`ifdef ACCUM_SAT_EN
        run_packet("povf", 30, 1, 32'h7FFF_FFFF, 1'b1, CNT_W'(2));
`else
        run_packet("povf", 30, 1, 32'h8000_0000, 1'b1, CNT_W'(2));
`endif

        // Carry-out without signed overflow
        beat_q = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        run_packet("carry", 30, 0, 32'h8000_0000, 1'b0, CNT_W'(3));

        // Single beat held for 5 cycles
        beat_q = '{32'h1234_5678};
        run_packet("single", 0, 5, 32'h1234_5678, 1'b0, CNT_W'(1));

        // Overflow then recovery, sticky flag
        beat_q = '{32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
`ifdef ACCUM_SAT_EN
        run_packet("sticky", 20, 2, 32'h7FFF_FFFE, 1'b1, CNT_W'(3));
`else
        run_packet("sticky", 20, 2, 32'h7FFF_FFFF, 1'b1, CNT_W'(3));
`endif

        // Negative overflow (model-derived)
        beat_q = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005};
        model(ms, mo, mc);
        run_packet("novf", 10, 1, ms, mo, mc);

        // Asynchronous reset mid-packet after 2 of 4 beats
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd3; in_last = 1'b0;
        @(negedge clk);
        in_data = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_inrdy", 32'(in_ready),  32'd0);
        chk("arst_sum",   out_sum,        32'h0);
        chk("arst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_q = '{32'd5, 32'd5};
        run_packet("post_rst", 0, 0, 32'd10, 1'b0, CNT_W'(2));

        // Randomized packets, biased toward the signed rails to provoke overflow
        for (int p = 0; p < 20; p++) begin
            beat_q.delete();
            len = int'($urandom_range(1, 7));
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(3))
                    0:       beat_q.push_back(32'h7FFF_0000 + 32'($urandom_range(65535)));
                    1:       beat_q.push_back(32'h8000_0000 + 32'($urandom_range(65535)));
                    default: beat_q.push_back($urandom);
                endcase
            end
            model(ms, mo, mc);
            run_packet($sformatf("rnd%0d", p), 40, int'($urandom_range(3)), ms, mo, mc);
        end

        // Long packet: count saturates at 255 while the sum keeps accumulating
        beat_q.delete();
        for (int b = 0; b < 300; b++) beat_q.push_back(32'($urandom_range(1000)));
        model(ms, mo, mc);
        run_packet("satcnt", 0, 1, ms, mo, mc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
